// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one combinational half-precision FPU adder between N_REQ requesters.
// Build option: define FPU_ARB_RR_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module fpu_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [16*N_REQ-1:0] a_in,
  input  logic [16*N_REQ-1:0] b_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [15:0]         rsp_data,
  output logic [15:0]         fpu_a,
  output logic [15:0]         fpu_b,
  input  logic [15:0]         fpu_r,
  output logic                busy,
  output logic [15:0]         op_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   w_q, w_d;
  logic [15:0]        op_a_q, op_a_d;
  logic [15:0]        op_b_q, op_b_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic [15:0]        op_count_q, op_count_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   win_s;
`ifdef FPU_ARB_RR_EN
  logic [IDX_W-1:0]   last_w_q, last_w_d;
`endif

  // Winner selection: later loop iterations override, so the nearest candidate wins
  always_comb begin
    int idx;
    idx   = 0;
    win_s = '0;
`ifdef FPU_ARB_RR_EN
    for (int k = N_REQ; k >= 1; k--) begin
      idx   = (int'(last_w_q) + k) % N_REQ;
      win_s = req[idx] ? IDX_W'(idx) : win_s;
    end
`else
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx   = i;
      win_s = req[idx] ? IDX_W'(idx) : win_s;
    end
`endif
  end

  // Next-state and registered-output computation for the IDLE/EXEC/RESP sequencer
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    op_count_d  = op_count_q;
`ifdef FPU_ARB_RR_EN
    last_w_d    = last_w_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d        = EXEC;
          w_d            = win_s;
          op_a_d         = a_in[int'(win_s)*16 +: 16];
          op_b_d         = b_in[int'(win_s)*16 +: 16];
          gnt_d[win_s]   = 1'b1;
`ifdef FPU_ARB_RR_EN
          last_w_d       = win_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d          = RESP;
        rsp_data_d       = fpu_r;
        rsp_valid_d[w_q] = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        if (op_count_q != 16'hFFFF) begin
          op_count_d = op_count_q + 16'd1;
        end else begin
          op_count_d = op_count_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; an async reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      op_a_q      <= 16'h0000;
      op_b_q      <= 16'h0000;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 16'h0000;
      op_count_q  <= 16'h0000;
      busy_q      <= 1'b0;
`ifdef FPU_ARB_RR_EN
      last_w_q    <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      op_count_q  <= op_count_d;
      busy_q      <= busy_d;
`ifdef FPU_ARB_RR_EN
      last_w_q    <= last_w_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign fpu_a     = op_a_q;
  assign fpu_b     = op_b_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: a lookup-table FPU stands in for the adder,
// expected grants/responses are queued by stimulus and checked by a monitor.
module tb_fpu_arbiter;
  localparam int N_REQ = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] a_in;
  logic [16*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rsp_valid;
  logic [15:0]         rsp_data;
  logic [15:0]         fpu_a;
  logic [15:0]         fpu_b;
  logic [15:0]         fpu_r;
  logic                busy;
  logic [15:0]         op_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } rsp_t;

  rsp_t rsp_q[$];
  int   gnt_q[$];

  fpu_arbiter #(.N_REQ(N_REQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .fpu_a    (fpu_a),
    .fpu_b    (fpu_b),
    .fpu_r    (fpu_r),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Stand-in FPU: only the operand pairs used below, each result hand-computed
  always_comb begin
    case ({fpu_a, fpu_b})
      32'h4400_4200: fpu_r = 16'h4700;
      32'h4400_C400: fpu_r = 16'h0000;
      32'h3C00_3C00: fpu_r = 16'h4000;
      default:       fpu_r = fpu_a ^ fpu_b;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents gnt or rsp_valid
  always @(negedge clk) begin : mon
    int   ei;
    rsp_t er;
    if (rst_n) begin
      if (|gnt) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 64'(gnt), 64'd0);
        end else begin
          ei = gnt_q.pop_front();
          check("gnt_order", 64'(gnt), 64'(1 << ei));
        end
      end
      if (|rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          er = rsp_q.pop_front();
          check("rsp_valid_idx", 64'(rsp_valid), 64'(1 << er.idx));
          check("rsp_data", 64'(rsp_data), 64'(er.data));
        end
      end
      if ((|gnt) && (|rsp_valid)) begin
        check("gnt_rsp_overlap", 64'(gnt & rsp_valid), 64'd0);
      end
    end
  end

  // One request from an idle arbiter: gnt next cycle, result, then op_count
  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [15:0] exp_cnt);
    int n;
    @(negedge clk);
    a_in[16*i +: 16] = a;
    b_in[16*i +: 16] = b;
    req[i] = 1'b1;
    gnt_q.push_back(i);
    rsp_q.push_back('{idx: i, data: r});
    n = 0;
    @(negedge clk);
    while (!gnt[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gnt_latency", 64'(n), 64'd0);
    check("fpu_a_hold", 64'(fpu_a), 64'(a));
    check("fpu_b_hold", 64'(fpu_b), 64'(b));
    check("busy_exec", 64'(busy), 64'd1);
    @(posedge clk);
    #1 req[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'd0);
    check("op_count", 64'(op_count), 64'(exp_cnt));
  endtask

  initial begin
    int seen;
    int n;
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Quiet after reset
    repeat (10) begin
      @(negedge clk);
      check("reset_outputs", 64'({gnt, rsp_valid, busy, rsp_data, fpu_a, fpu_b}), 64'd0);
      check("reset_op_count", 64'(op_count), 64'd0);
    end

    do_op(0, 16'h4400, 16'h4200, 16'h4700, 16'd1);

    // Clean reset, then abort an operation in its EXEC cycle
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("op_count_cleared", 64'(op_count), 64'd0);
    a_in[15:0] = 16'h4400;
    b_in[15:0] = 16'h4200;
    req[0] = 1'b1;
    gnt_q.push_back(0);
    @(negedge clk);
    check("abort_gnt_seen", 64'(gnt), 64'd1);
    #2;
    rst_n  = 1'b0;
    req[0] = 1'b0;
    #1;
    check("abort_outputs", 64'({gnt, rsp_valid, busy, rsp_data, fpu_a, fpu_b}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_rsp", 64'({rsp_valid, busy}), 64'd0);
      check("abort_op_count", 64'(op_count), 64'd0);
    end

    do_op(0, 16'h4400, 16'h4200, 16'h4700, 16'd1);
    do_op(0, 16'h4400, 16'hC400, 16'h0000, 16'd2);
    do_op(3, 16'h3C00, 16'h3C00, 16'h4000, 16'd3);

    // All four requesters held high for five rounds
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      a_in[16*i +: 16] = 16'h3C00;
      b_in[16*i +: 16] = 16'h3C00;
    end
`ifdef FPU_ARB_RR_EN
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2); gnt_q.push_back(3); gnt_q.push_back(0);
    rsp_q.push_back('{idx: 0, data: 16'h4000});
    rsp_q.push_back('{idx: 1, data: 16'h4000});
    rsp_q.push_back('{idx: 2, data: 16'h4000});
    rsp_q.push_back('{idx: 3, data: 16'h4000});
    rsp_q.push_back('{idx: 0, data: 16'h4000});
`else
    repeat (5) begin
      gnt_q.push_back(0);
      rsp_q.push_back('{idx: 0, data: 16'h4000});
    end
`endif
    req  = 4'b1111;
    seen = 0;
    n    = 0;
    while (seen < 5 && n < 40) begin
      @(negedge clk);
      n++;
      if (|rsp_valid) seen++;
    end
    check("rr_round_count", 64'(seen), 64'd5);
    req = '0;
    repeat (2) @(negedge clk);
    check("rr_busy_idle", 64'(busy), 64'd0);
    check("rr_op_count", 64'(op_count), 64'd8);

    // Saturation of op_count
    @(negedge clk);
    force dut.op_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.op_count_q;
    check("sat_preset", 64'(op_count), 64'hFFFE);
    do_op(1, 16'h3C00, 16'h3C00, 16'h4000, 16'hFFFF);
    do_op(2, 16'h4400, 16'h4200, 16'h4700, 16'hFFFF);
    do_op(0, 16'h4400, 16'hC400, 16'h0000, 16'hFFFF);

    repeat (3) @(negedge clk);
    check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
